// File: rtl/z80_bus_responder_if.sv
// rtl/z80_bus_responder_if.sv - Z80 external bus bundle between CPU initiator and responder
//
// master : CPU side; drives A, nMREQ, nIORQ, nRD, nWR, nM1, nRFSH, WRITE_D
//          and observes READ_D, nWAIT and the write-observation/error outputs.
// slave  : responder side; the mirror image of master.
//   A[15:0]        address from CPU
//   nMREQ/nIORQ    memory / IO request, active low
//   nRD/nWR        read / write strobes, active low
//   nM1            opcode fetch / interrupt acknowledge qualifier, active low
//   nRFSH          refresh, active low
//   WRITE_D[7:0]   write data from CPU
//   READ_D[7:0]    registered read data to CPU
//   nWAIT          registered wait request, active low
//   wr_strobe      one-cycle pulse when a write commits
//   wr_is_io       committed write targeted IO space
//   wr_addr[15:0]  committed write address
//   wr_data[7:0]   committed write data
//   proto_err      one-cycle pulse on an illegal strobe combination
interface z80_bus_responder_if;
  logic [15:0] A;
  logic        nMREQ;
  logic        nIORQ;
  logic        nRD;
  logic        nWR;
  logic        nM1;
  logic        nRFSH;
  logic [7:0]  WRITE_D;
  logic [7:0]  READ_D;
  logic        nWAIT;
  logic        wr_strobe;
  logic        wr_is_io;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        proto_err;

  modport master (
    output A, nMREQ, nIORQ, nRD, nWR, nM1, nRFSH, WRITE_D,
    input  READ_D, nWAIT, wr_strobe, wr_is_io, wr_addr, wr_data, proto_err
  );

  modport slave (
    input  A, nMREQ, nIORQ, nRD, nWR, nM1, nRFSH, WRITE_D,
    output READ_D, nWAIT, wr_strobe, wr_is_io, wr_addr, wr_data, proto_err
  );
endinterface

// File: rtl/z80_bus_responder.sv
// rtl/z80_bus_responder.sv - deterministic memory/IO responder for the Z80 external bus
//
// clk    : sole clock, all state on rising edge
// reset  : asynchronous, active high; aborts any access, RAM contents kept
// bus    : z80_bus_responder_if.slave (CPU request in, read data, nWAIT,
//          write-observation port and proto_err out)
// Backing store is 2**MEM_AW bytes of RAM (address wraps) plus 16 IO registers.
// Every accepted access holds nWAIT low for WAIT_STATES cycles, then performs
// exactly one read or write on a single edge.
module z80_bus_responder #(
  parameter int         MEM_AW        = 10,
  parameter int         WAIT_STATES   = 1,
  parameter logic [7:0] INTACK_VECTOR = 8'hFF
) (
  input logic          clk,
  input logic          reset,
  z80_bus_responder_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE} state_t;
  typedef enum logic [2:0] {K_NONE, K_MEM_RD, K_MEM_WR, K_IO_RD, K_IO_WR, K_INTACK} kind_t;

  state_t      r_state;
  state_t      w_state_nxt;
  kind_t       r_kind;
  kind_t       w_kind;
  kind_t       w_kind_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_nwait_nxt;
  logic        w_do_access;
  logic        w_proto_nxt;
  logic        w_illegal;
  logic        w_mem_we;

  logic [7:0]  r_mem [0:(1<<MEM_AW)-1];
  logic [7:0]  r_io  [0:15];

  logic [7:0]  r_read_d;
  logic        r_nwait;
  logic        r_wr_strobe;
  logic        r_wr_is_io;
  logic [15:0] r_wr_addr;
  logic [7:0]  r_wr_data;
  logic        r_proto_err;

  // Request classification of the current bus cycle. Intack ignores the
  // strobes; refresh cycles decode to nothing.
  always_comb begin
    w_kind = K_NONE;
    if (!bus.nIORQ && !bus.nM1)
      w_kind = K_INTACK;
    else if (!bus.nMREQ && bus.nRFSH && !bus.nRD && bus.nWR)
      w_kind = K_MEM_RD;
    else if (!bus.nMREQ && bus.nRFSH && bus.nRD && !bus.nWR)
      w_kind = K_MEM_WR;
    else if (!bus.nIORQ && bus.nM1 && !bus.nRD && bus.nWR)
      w_kind = K_IO_RD;
    else if (!bus.nIORQ && bus.nM1 && bus.nRD && !bus.nWR)
      w_kind = K_IO_WR;
  end

  assign w_illegal = (!bus.nRD && !bus.nWR) || (!bus.nMREQ && !bus.nIORQ);

  // Next state. WAIT and ACTIVE both leave as soon as the bus stops showing
  // the request kind that was accepted, so a held strobe never repeats.
  always_comb begin
    w_state_nxt = r_state;
    w_kind_nxt  = r_kind;
    w_cnt_nxt   = r_cnt;
    w_nwait_nxt = 1'b1;
    w_do_access = 1'b0;
    w_proto_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_illegal) begin
          w_proto_nxt = 1'b1;
        end else if (w_kind != K_NONE) begin
          w_kind_nxt = w_kind;
          if (WAIT_STATES == 0) begin
            w_state_nxt = S_ACTIVE;
            w_do_access = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = 4'(WAIT_STATES - 1);
            w_nwait_nxt = 1'b0;
          end
        end
      end
      S_WAIT: begin
        if (w_kind != r_kind) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = S_ACTIVE;
          w_do_access = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt - 4'd1;
          w_nwait_nxt = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (w_kind != r_kind)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_kind      <= K_NONE;
      r_cnt       <= 4'd0;
      r_nwait     <= 1'b1;
      r_read_d    <= 8'h00;
      r_wr_strobe <= 1'b0;
      r_wr_is_io  <= 1'b0;
      r_wr_addr   <= 16'h0000;
      r_wr_data   <= 8'h00;
      r_proto_err <= 1'b0;
      for (int i = 0; i < 16; i++)
        r_io[i] <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_kind      <= w_kind_nxt;
      r_cnt       <= w_cnt_nxt;
      r_nwait     <= w_nwait_nxt;
      r_proto_err <= w_proto_nxt;
      r_wr_strobe <= 1'b0;
      if (w_do_access) begin
        case (w_kind)
          K_MEM_RD: r_read_d <= r_mem[bus.A[MEM_AW-1:0]];
          K_IO_RD:  r_read_d <= r_io[bus.A[3:0]];
          K_INTACK: r_read_d <= INTACK_VECTOR;
          K_MEM_WR: begin
            r_wr_strobe <= 1'b1;
            r_wr_is_io  <= 1'b0;
            r_wr_addr   <= bus.A;
            r_wr_data   <= bus.WRITE_D;
          end
          K_IO_WR: begin
            r_io[bus.A[3:0]] <= bus.WRITE_D;
            r_wr_strobe <= 1'b1;
            r_wr_is_io  <= 1'b1;
            r_wr_addr   <= bus.A;
            r_wr_data   <= bus.WRITE_D;
          end
          default: ;
        endcase
      end
    end
  end

  // RAM has no reset so its contents survive one; the write is still
  // suppressed while reset is held so an aborted access never lands.
  assign w_mem_we = w_do_access && (w_kind == K_MEM_WR) && !reset;

  always_ff @(posedge clk) begin
    if (w_mem_we)
      r_mem[bus.A[MEM_AW-1:0]] <= bus.WRITE_D;
  end

  assign bus.READ_D    = r_read_d;
  assign bus.nWAIT     = r_nwait;
  assign bus.wr_strobe = r_wr_strobe;
  assign bus.wr_is_io  = r_wr_is_io;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.proto_err = r_proto_err;

endmodule
